// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for a VGA-style display.
// Two counters track the pixel column and the line. All outputs are
// registered and are computed from the *next* counter values, so every
// output in a given cycle agrees with the hpos/vpos presented in that cycle.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        hsync,
  output logic        vsync,
  output logic        visible,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  // Last valid position on each axis (total - 1) and the sync windows.
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  hpos_r;
  logic [9:0]  vpos_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        visible_r;
  logic        line_start_r;
  logic        frame_start_r;
  logic [15:0] frame_count_r;

  logic        h_wrap_s;
  logic        v_wrap_s;
  logic [9:0]  hpos_nxt_s;
  logic [9:0]  vpos_nxt_s;
  logic        hsync_nxt_s;
  logic        vsync_nxt_s;
  logic        visible_nxt_s;

  // Next raster position and the decoded sync/visible levels for that position.
  always_comb begin
    h_wrap_s      = 1'b0;
    v_wrap_s      = 1'b0;
    hpos_nxt_s    = hpos_r;
    vpos_nxt_s    = vpos_r;
    hsync_nxt_s   = 1'b1;
    vsync_nxt_s   = 1'b1;
    visible_nxt_s = 1'b0;

    h_wrap_s = (hpos_r == H_LAST);
    v_wrap_s = h_wrap_s && (vpos_r == V_LAST);

    if (h_wrap_s) begin
      hpos_nxt_s = 10'd0;
    end else begin
      hpos_nxt_s = hpos_r + 10'd1;
    end

    if (v_wrap_s) begin
      vpos_nxt_s = 10'd0;
    end else if (h_wrap_s) begin
      vpos_nxt_s = vpos_r + 10'd1;
    end else begin
      vpos_nxt_s = vpos_r;
    end

    hsync_nxt_s   = ~((hpos_nxt_s >= HS_START) && (hpos_nxt_s < HS_END));
    vsync_nxt_s   = ~((vpos_nxt_s >= VS_START) && (vpos_nxt_s < VS_END));
    visible_nxt_s = (hpos_nxt_s < H_VIS) && (vpos_nxt_s < V_VIS);
  end

  // Raster state: advance on enabled clocks, hold (with pulses cleared) otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_r        <= 10'd0;
      vpos_r        <= 10'd0;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      visible_r     <= 1'b1;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= 16'd0;
    end else if (ena) begin
      hpos_r        <= hpos_nxt_s;
      vpos_r        <= vpos_nxt_s;
      hsync_r       <= hsync_nxt_s;
      vsync_r       <= vsync_nxt_s;
      visible_r     <= visible_nxt_s;
      line_start_r  <= h_wrap_s;
      frame_start_r <= v_wrap_s;
      frame_count_r <= frame_count_r + {15'd0, v_wrap_s};
    end else begin
      hpos_r        <= hpos_r;
      vpos_r        <= vpos_r;
      hsync_r       <= hsync_r;
      vsync_r       <= vsync_r;
      visible_r     <= visible_r;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= frame_count_r;
    end
  end

  assign hpos        = hpos_r;
  assign vpos        = vpos_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign visible     = visible_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: one default-timing instance (line timing), one
// small-timing instance (frame, enable, async reset) and one degenerate
// 1x1 instance used to reach the frame counter wrap quickly.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: default parameters
  logic        rst_a = 1'b0, ena_a = 1'b1;
  logic [9:0]  hpos_a, vpos_a;
  logic        hsync_a, vsync_a, visible_a, ls_a, fs_a;
  logic [15:0] fc_a;
  vga_sync_gen dut_a (
    .clk(clk), .rst_n(rst_a), .ena(ena_a), .hpos(hpos_a), .vpos(vpos_a),
    .hsync(hsync_a), .vsync(vsync_a), .visible(visible_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_count(fc_a));

  // Instance B: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), 98 clocks per frame
  logic        rst_b = 1'b0, ena_b = 1'b1;
  logic [9:0]  hpos_b, vpos_b;
  logic        hsync_b, vsync_b, visible_b, ls_b, fs_b;
  logic [15:0] fc_b;
  vga_sync_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                 .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .ena(ena_b), .hpos(hpos_b), .vpos(vpos_b),
    .hsync(hsync_b), .vsync(vsync_b), .visible(visible_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_count(fc_b));

  // Instance C: 1x1 raster, a frame completes on every clock
  logic        rst_c = 1'b0, ena_c = 1'b1;
  logic [9:0]  hpos_c, vpos_c;
  logic        hsync_c, vsync_c, visible_c, ls_c, fs_c;
  logic [15:0] fc_c;
  vga_sync_gen #(.H_VISIBLE(1), .H_FRONT(0), .H_SYNC(0), .H_BACK(0),
                 .V_VISIBLE(1), .V_FRONT(0), .V_SYNC(0), .V_BACK(0)) dut_c (
    .clk(clk), .rst_n(rst_c), .ena(ena_c), .hpos(hpos_c), .vpos(vpos_c),
    .hsync(hsync_c), .vsync(vsync_c), .visible(visible_c), .line_start(ls_c),
    .frame_start(fs_c), .frame_count(fc_c));

  typedef struct {
    int          cyc;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs, vs, vis, ls, fs;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[19];

  // Advance one clock and step past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [40:0] obs_b();
    return {hpos_b, vpos_b, hsync_b, vsync_b, visible_b, ls_b, fs_b, fc_b};
  endfunction

  task automatic check_b(input string name, input logic [9:0] h, input logic [9:0] v,
                         input logic hs, input logic vs, input logic vis,
                         input logic ls, input logic fs, input logic [15:0] fc);
    logic [40:0] exp;
    logic [40:0] act;
    exp = {h, v, hs, vs, vis, ls, fs, fc};
    act = obs_b();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b vis=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b vis=%b ls=%b fs=%b fc=%0d",
               name, act[40:31], act[30:21], act[20], act[19], act[18], act[17], act[16], act[15:0],
               h, v, hs, vs, vis, ls, fs, fc);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kb;
    int hs_cnt, hs_first, hs_last, hpos_err, vis639, vis640;
    int fs_cnt, fs_first, hs_err, sync_err;

    //        cyc   h      v      hs    vs    vis   ls    fs    fc
    tbl[0]  = '{0,   10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1,   10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{7,   10'd7, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{8,   10'd8, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{10,  10'd10, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{11,  10'd11, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{12,  10'd12, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{13,  10'd13, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{14,  10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[9]  = '{15,  10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[10] = '{56,  10'd0, 10'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[11] = '{70,  10'd0, 10'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[12] = '{83,  10'd13, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[13] = '{84,  10'd0, 10'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[14] = '{97,  10'd13, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[15] = '{98,  10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
    tbl[16] = '{99,  10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[17] = '{196, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2};
    tbl[18] = '{290, 10'd10, 10'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};

    repeat (2) tick();

    // ---- Instance A: one default line ----
    rst_a = 1'b1;
    check_int("a_reset_hsync", int'(hsync_a), 1);
    check_int("a_reset_visible", int'(visible_a), 1);
    hs_cnt = 0; hs_first = -1; hs_last = -1; hpos_err = 0; vis639 = -1; vis640 = -1;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (hsync_a == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
        hs_last = k;
      end
      if (int'(hpos_a) != (k % 800)) hpos_err++;
      if (k == 639) vis639 = int'(visible_a);
      if (k == 640) vis640 = int'(visible_a);
    end
    check_int("a_hsync_low_count", hs_cnt, 96);
    check_int("a_hsync_first", hs_first, 656);
    check_int("a_hsync_last", hs_last, 751);
    check_int("a_hpos_track_errors", hpos_err, 0);
    check_int("a_visible_639", vis639, 1);
    check_int("a_visible_640", vis640, 0);
    check_int("a_hpos_800", int'(hpos_a), 0);
    check_int("a_vpos_800", int'(vpos_a), 1);
    check_int("a_line_start_800", int'(ls_a), 1);

    // ---- Instance B: table-driven vectors ----
    rst_b = 1'b1;
    kb = 0;
    for (int i = 0; i < 19; i++) begin
      while (kb < tbl[i].cyc) begin
        tick();
        kb++;
      end
      check_b($sformatf("b_vec_cyc%0d", tbl[i].cyc), tbl[i].h, tbl[i].v, tbl[i].hs,
              tbl[i].vs, tbl[i].vis, tbl[i].ls, tbl[i].fs, tbl[i].fc);
    end

    // ---- Instance B: enable freeze at last visible pixel ----
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    repeat (49) tick();
    check_b("b_pre_freeze", 10'd7, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    ena_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_b($sformatf("b_frozen_%0d", i), 10'd7, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    end
    ena_b = 1'b1;
    tick();
    check_b("b_resume", 10'd8, 10'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    repeat (48) tick();
    check_b("b_frame_pulse", 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1);
    ena_b = 1'b0;
    tick();
    check_b("b_pulse_cleared", 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
    ena_b = 1'b1;
    tick();
    check_b("b_after_pulse", 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);

    // ---- Instance B: asynchronous reset mid-frame ----
    repeat (80) tick();
    check_b("b_pre_reset", 10'd11, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    #3;
    rst_b = 1'b0;
    #1;
    check_b("b_async_reset", 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    check_b("b_reset_held", 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    rst_b = 1'b1;
    check_b("b_release_0", 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    check_b("b_release_1", 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    check_b("b_release_2", 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);

    // ---- Instance B: 300 clocks of frame cadence ----
    fs_cnt = 0; fs_first = -1; hs_cnt = 0; hs_err = 0;
    for (int k = 3; k <= 300; k++) begin
      tick();
      if (fs_b) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        if ((k % 98) != 0) hs_err++;
      end
      if (!hsync_b) hs_cnt++;
      if ((hsync_b == 1'b0) != ((hpos_b == 10'd10) || (hpos_b == 10'd11))) hs_err++;
      if (hpos_b >= 10'd14 || vpos_b >= 10'd7) hs_err++;
    end
    check_int("b_frame_start_count", fs_cnt, 3);
    check_int("b_frame_start_first", fs_first, 98);
    check_int("b_hsync_low_count", hs_cnt, 42);
    check_int("b_cadence_errors", hs_err, 0);
    check_int("b_frame_count_300", int'(fc_b), 3);

    // ---- Instance C: frame counter wrap ----
    rst_c = 1'b1;
    sync_err = 0;
    repeat (65535) begin
      tick();
      if (!hsync_c || !vsync_c || !fs_c || !ls_c) sync_err++;
    end
    check_int("c_pulse_sync_errors", sync_err, 0);
    check_int("c_frame_count_ffff", int'(fc_c), 65535);
    tick();
    check_int("c_frame_count_wrap", int'(fc_c), 0);
    check_int("c_frame_start_wrap", int'(fs_c), 1);
    check_int("c_hpos_wrap", int'(hpos_c), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
